// File: rtl/lcd_seq_pkg.sv
// Shared encodings for the LCD status-screen stimulus sequencer.
// Mode picks the bar walk; phase separates the face sweep from the per-channel walks.
package lcd_seq_pkg;

   typedef enum logic [1:0] {
      SWEEP_UP   = 2'd0,
      SWEEP_DOWN = 2'd1,
      PINGPONG   = 2'd2,
      FACES_ONLY = 2'd3
   } mode_e;

   typedef enum logic {
      PH_FACE = 1'b0,
      PH_CHAN = 1'b1
   } phase_e;

   // Index width that stays at least one bit for degenerate single-entry ranges.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Step-event source: tick counter, single-step edge detect, pending/overrun flags.
// advance is combinational off pending|event and ready; an event arriving while one is already held and blocked is dropped.
module step_timer
   import lcd_seq_pkg::*;
#(
   parameter int STEP_CYCLES = 64000000
) (
   input  logic clk,
   input  logic arst_n,
   input  logic run,
   input  logic step,
   input  logic ready,
   output logic advance,
   output logic overrun
);

   localparam int TW = idx_width(STEP_CYCLES);
   localparam logic [TW-1:0] LAST_CNT = TW'(STEP_CYCLES - 1);

   logic [TW-1:0] cnt;
   logic          step_q;
   logic          pending;
   logic          tick;
   logic          step_rise;
   logic          evt;

   assign tick      = run && (cnt == LAST_CNT);
   assign step_rise = step && !step_q && !run;
   assign evt       = tick || step_rise;

   // A fresh event is forwarded in its own cycle so ready=1 gives one-cycle latency.
   assign advance = (pending || evt) && ready;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt     <= '0;
         step_q  <= 1'b0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         step_q <= step;

         if (tick) begin
            cnt <= '0;
         end else if (run) begin
            cnt <= cnt + TW'(1);
         end

         if (ready) begin
            pending <= pending && evt;
         end else begin
            pending <= pending || evt;
         end

         if (evt && pending && !ready) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_stat_sequencer.sv
// Walks the face index and status-bar values through the selected pattern, one frame per step event.
// Outputs register one cycle after advance; frames are held until the LCD controller raises ready.
module lcd_stat_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int  NUM_FACES    = 9,
   parameter int  NUM_CHANNELS = 3,
   parameter int  MAX_VALUE    = 5,
   parameter int  STEP_CYCLES  = 64000000,
   localparam int VW           = $clog2(MAX_VALUE + 1),
   localparam int FW           = $clog2(NUM_FACES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       run,
   input  logic                       step,
   input  logic [1:0]                 mode,
   input  logic                       ready,
   output logic [FW-1:0]              face,
   output logic [NUM_CHANNELS*VW-1:0] values,
   output logic                       update,
   output logic                       wrap,
   output logic                       overrun
);

   localparam int            CW        = idx_width(NUM_CHANNELS);
   localparam logic [FW-1:0] LAST_FACE = FW'(NUM_FACES - 1);
   localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHANNELS - 1);
   localparam logic [VW-1:0] MAXV      = VW'(MAX_VALUE);

   logic          advance;
   phase_e        phase;
   mode_e         mode_q;
   logic [CW-1:0] chan;
   logic [VW-1:0] val_q [NUM_CHANNELS];
   logic          dir_up;
   logic [VW-1:0] cur_val;
   logic [VW-1:0] entry_val;
   logic          entry_up;
   logic          wrap_now;

   step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .clk     (clk),
      .arst_n  (reset),
      .run     (run),
      .step    (step),
      .ready   (ready),
      .advance (advance),
      .overrun (overrun)
   );

   assign cur_val   = val_q[chan];
   assign entry_up  = (mode_q == SWEEP_UP);
   assign entry_val = entry_up ? '0 : (MAXV - VW'(1));

   // Wrap fires on the step after the last face (faces-only) or after the last channel reaches full scale.
   always_comb begin
      wrap_now = 1'b0;
      if (advance) begin
         if (phase == PH_FACE) begin
            wrap_now = (face == LAST_FACE) && (mode_q == FACES_ONLY);
         end else begin
            wrap_now = (cur_val == MAXV) && (chan == LAST_CHAN);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase  <= PH_FACE;
         mode_q <= mode_e'(mode);
         chan   <= '0;
         face   <= '0;
         dir_up <= 1'b0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            val_q[c] <= MAXV;
         end
         update <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         update <= advance;
         wrap   <= wrap_now;

         if (wrap_now) begin
            phase  <= PH_FACE;
            mode_q <= mode_e'(mode);
            chan   <= '0;
            face   <= '0;
            dir_up <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
               val_q[c] <= MAXV;
            end
         end else if (advance) begin
            case (phase)
               PH_FACE: begin
                  if (face != LAST_FACE) begin
                     face <= face + FW'(1);
                  end else begin
                     phase    <= PH_CHAN;
                     chan     <= '0;
                     val_q[0] <= entry_val;
                     dir_up   <= entry_up;
                  end
               end
               PH_CHAN: begin
                  // Every walk ends back at full scale, which hands over to the next channel.
                  if (cur_val == MAXV) begin
                     chan                <= chan + CW'(1);
                     val_q[chan + CW'(1)] <= entry_val;
                     dir_up              <= entry_up;
                  end else if (dir_up) begin
                     val_q[chan] <= cur_val + VW'(1);
                  end else if (cur_val == '0) begin
                     if (mode_q == PINGPONG) begin
                        val_q[chan] <= VW'(1);
                        dir_up      <= 1'b1;
                     end else begin
                        val_q[chan] <= MAXV;
                     end
                  end else begin
                     val_q[chan] <= cur_val - VW'(1);
                  end
               end
               default: begin
                  phase <= PH_FACE;
               end
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_values
      assign values[g*VW +: VW] = val_q[g];

      ap_val_range: assert property (@(posedge clk) disable iff (!reset) val_q[g] <= MAXV);
   end

   ap_face_range: assert property (@(posedge clk) disable iff (!reset) face <= LAST_FACE);
   ap_wrap_upd:   assert property (@(posedge clk) disable iff (!reset) wrap |-> update);

endmodule
